// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2-HMAC-SHA256 sequencing controller.
package pbkdf2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    REJECT
  } state_t;

  localparam int unsigned SALT_MAX_BYTES = 51;
  localparam int unsigned U_BYTES        = 32;
  localparam logic [31:0] BLOCK_IDX      = 32'h0000_0001;

endpackage

// File: rtl/pbkdf2_msg_builder.sv
// First-iteration message: left-aligned salt with big-endian INT(1) written
// over the four bytes that immediately follow the salt.
module pbkdf2_msg_builder
  import pbkdf2_pkg::*;
(
  input  logic [511:0] salt,
  input  logic [5:0]   salt_len,
  output logic [511:0] msg,
  output logic [5:0]   len
);

  logic [8:0] shift;

  always_comb begin
    shift = {salt_len, 3'b000};
    msg   = (salt & ~({32'hFFFF_FFFF, 480'b0} >> shift))
          | ({BLOCK_IDX, 480'b0} >> shift);
    len   = salt_len + 6'd4;
  end

endmodule

// File: rtl/pbkdf2_ctrl.sv
// Drives one hmac_sha256 engine c times to form a single-block PBKDF2 key
// T = U1 ^ ... ^ Uc, owning the iteration count and both job handshakes.
module pbkdf2_ctrl
  import pbkdf2_pkg::*;
#(
  parameter int unsigned ITER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              v_i,
  output logic              r_o,
  input  logic [511:0]      pass_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic              v_o,
  input  logic              r_i,
  output logic              busy_o,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  state_t            state;
  logic [ITER_W-1:0] c_q;
  logic [ITER_W-1:0] cnt;
  logic [ITER_W:0]   cnt_nx;
  logic [255:0]      t_q;
  logic [255:0]      t_nx;
  logic [511:0]      first_msg;
  logic [5:0]        first_len;

  pbkdf2_msg_builder u_msg (
    .salt     (salt_i),
    .salt_len (salt_len_i),
    .msg      (first_msg),
    .len      (first_len)
  );

  always_comb begin
    cnt_nx = {1'b0, cnt} + (ITER_W+1)'(1);
    t_nx   = (cnt == '0) ? hmac_prf_i : (t_q ^ hmac_prf_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      r_o        <= 1'b0;
      v_o        <= 1'b0;
      busy_o     <= 1'b0;
      dk_o       <= '0;
      err_o      <= 1'b0;
      hmac_key_o <= '0;
      hmac_msg_o <= '0;
      hmac_len_o <= '0;
      hmac_v_o   <= 1'b0;
      hmac_r_o   <= 1'b0;
      c_q        <= '0;
      cnt        <= '0;
      t_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          r_o <= 1'b1;
          if (v_i && r_o) begin
            r_o        <= 1'b0;
            busy_o     <= 1'b1;
            hmac_key_o <= pass_i;
            c_q        <= (iter_i == '0) ? ITER_W'(1) : iter_i;
            cnt        <= '0;
            t_q        <= '0;
            if (salt_len_i > 6'(SALT_MAX_BYTES)) begin
              state <= REJECT;
            end else begin
              state      <= ISSUE;
              hmac_v_o   <= 1'b1;
              hmac_msg_o <= first_msg;
              hmac_len_o <= first_len;
            end
          end
        end
        ISSUE: begin
          if (hmac_r_i) begin
            hmac_v_o <= 1'b0;
            hmac_r_o <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (hmac_v_i) begin
            hmac_r_o <= 1'b0;
            t_q      <= t_nx;
            cnt      <= cnt_nx[ITER_W-1:0];
            if (cnt_nx == {1'b0, c_q}) begin
              state <= DONE;
              v_o   <= 1'b1;
              dk_o  <= t_nx;
              err_o <= 1'b0;
            end else begin
              // The message register is the only copy of U kept between calls.
              state      <= ISSUE;
              hmac_v_o   <= 1'b1;
              hmac_msg_o <= {hmac_prf_i, 256'b0};
              hmac_len_o <= 6'(U_BYTES);
            end
          end
        end
        REJECT: begin
          state <= DONE;
          v_o   <= 1'b1;
          dk_o  <= '0;
          err_o <= 1'b1;
        end
        DONE: begin
          if (r_i) begin
            v_o    <= 1'b0;
            busy_o <= 1'b0;
            r_o    <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
